// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state encoding and word geometry for the instruction memory loader.
package imem_loader_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles accepted bytes into a little-endian 32-bit word.
// Ports: clk/reset (async, active-high); clear restarts at byte 0; accept marks a
// completed byte handshake carrying data; word is the full word presented together
// with word_ready in the cycle the final byte is accepted.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready
);
  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
  logic [1:0]  idx;
  logic [23:0] lo;
  assign word_ready = accept && idx == LAST;
  // The final byte bypasses the register so the word is complete in its accept cycle.
  assign word = {data, lo};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      lo  <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx + 2'd1;
      if (!word_ready) lo[{idx, 3'b000} +: 8] <= data;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a byte-streamed program image into instruction memory, stalling the CPU meanwhile.
// Ports: clk, reset (async, active-high); start/word_count begin a load; in_valid/in_ready/in_data
// form the byte stream; mem_we/mem_addr/mem_wdata drive the memory write port; busy stalls the CPU;
// done pulses at completion; checksum is the XOR of all words written by the last load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_SIZE = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [MEM_ADDR_SIZE:0] word_count,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [DATA_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  checksum
);
  localparam logic [MEM_ADDR_SIZE:0] DEPTH = {1'b1, {MEM_ADDR_SIZE{1'b0}}};
  localparam logic [MEM_ADDR_SIZE:0] ONE   = (MEM_ADDR_SIZE + 1)'(1);
  logic [1:0]             state, nxt;
  logic [MEM_ADDR_SIZE:0] remaining, clamped;
  logic                   accept, word_ready, take_start;
  logic [31:0]            word;
  assign accept     = in_valid && in_ready;
  assign take_start = state == IDLE && start;
  // Clamping the count keeps the final write inside memory, so the address never wraps.
  assign clamped    = word_count > DEPTH ? DEPTH : word_count;
  imem_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (take_start),
    .accept    (accept),
    .data      (in_data),
    .word      (word),
    .word_ready(word_ready)
  );
  always_comb begin
    nxt = state == IDLE  ? (start ? (clamped == '0 ? DONE : RECV) : IDLE)
        : state == RECV  ? (word_ready ? WRITE : RECV)
        : state == WRITE ? (remaining == ONE ? DONE : RECV)
        : IDLE;
  end
  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      state    <= nxt;
      in_ready <= nxt == RECV;
      busy     <= nxt == RECV || nxt == WRITE;
      mem_we   <= nxt == WRITE;
      done     <= nxt == DONE;
      if (word_ready) mem_wdata <= DATA_WIDTH'(word);
      if (take_start) begin
        remaining <= clamped;
        checksum  <= '0;
        mem_addr  <= '0;
      end
      if (state == WRITE) begin
        checksum  <= checksum ^ mem_wdata;
        mem_addr  <= mem_addr + DATA_WIDTH'(BYTES_PER_WORD);
        remaining <= remaining - ONE;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader.
module tb_imem_loader;
  localparam int AW = 9;
  localparam int DEPTH = 512;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  logic        clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [AW:0] word_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata, checksum;
  int          errors = 0, checks = 0, writes = 0;
  logic [31:0] last_addr = '0;
  wr_t         sb[$];
  wr_t         mon_e;
  logic [31:0] stim[$];

  imem_loader #(.DATA_WIDTH(32), .MEM_ADDR_SIZE(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      writes++;
      last_addr = mem_addr;
      check("write expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("mem_addr", mem_addr, mon_e.addr);
        check("mem_wdata", mem_wdata, mon_e.data);
      end
      check("in_ready in WRITE", 32'(in_ready), 0);
      check("busy in WRITE", 32'(busy), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1;
    in_data = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready wait", 32'(in_ready), 1);
    tick();
  endtask

  task automatic run_load(input int cnt, input int gap_at);
    logic [31:0] sum = '0;
    logic [31:0] w;
    int w0 = writes;
    int n = 0;
    for (int i = 0; i < stim.size(); i++) begin
      sum ^= stim[i];
      sb.push_back('{32'(4 * i), stim[i]});
    end
    start = 1;
    word_count = cnt[AW:0];
    tick();
    start = 0;
    check("busy after start", 32'(busy), 32'(stim.size() != 0));
    for (int i = 0; i < stim.size(); i++) begin
      w = stim[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        if (4 * i + k == gap_at) begin
          in_valid = 0;
          repeat (5) begin
            tick();
            check("no write in gap", 32'(mem_we), 0);
          end
        end
      end
    end
    in_valid = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    check("done", 32'(done), 1);
    check("done latency", n, 32'(stim.size() != 0));
    check("busy at done", 32'(busy), 0);
    check("checksum", checksum, sum);
    check("write count", writes - w0, stim.size());
    check("scoreboard drained", sb.size(), 0);
    tick();
    check("done one cycle", 32'(done), 0);
    check("idle in_ready", 32'(in_ready), 0);
    check("checksum held", checksum, sum);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst in_ready", 32'(in_ready), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst checksum", checksum, 0);
    @(negedge clk);
    reset = 0;
    tick();
    stim = '{32'h00000013};
    run_load(1, -1);
    stim = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    run_load(3, -1);
    stim = '{32'hDEADBEEF, 32'h12345678};
    run_load(2, 1);
    stim = {};
    run_load(0, -1);
    stim = {};
    for (int i = 0; i < DEPTH; i++) stim.push_back($urandom);
    run_load(600, -1);
    check("last addr", last_addr, 32'd2044);
    sb.push_back('{32'd0, 32'h11111111});
    sb.push_back('{32'd4, 32'h22222222});
    start = 1;
    word_count = 4;
    tick();
    start = 0;
    for (int i = 0; i < 8; i++) send_byte(i < 4 ? 8'h11 : 8'h22);
    send_byte(8'h33);
    in_valid = 0;
    #2 reset = 1;
    #1;
    check("mid rst in_ready", 32'(in_ready), 0);
    check("mid rst mem_we", 32'(mem_we), 0);
    check("mid rst mem_addr", mem_addr, 0);
    check("mid rst mem_wdata", mem_wdata, 0);
    check("mid rst busy", 32'(busy), 0);
    check("mid rst done", 32'(done), 0);
    check("mid rst checksum", checksum, 0);
    check("writes before reset", sb.size(), 0);
    tick();
    reset = 0;
    tick();
    stim = '{32'hCAFEF00D};
    run_load(1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
